// File: rtl/register_bank_mp_pkg.sv
// register_bank_mp_pkg: shared dump FSM states and default geometry for the register bank
package register_bank_mp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_e;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;

endpackage

// File: rtl/register_bank_mp_dump_seq.sv
// register_bank_mp_dump_seq: streams every bank entry over valid/ready, one beat per handshake
module register_bank_mp_dump_seq
    import register_bank_mp_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic               o_dump_valid,
    output logic [NB_REG-1:0]  o_dump_index,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_busy,
    output logic               o_dump_done
);

    dump_state_e        state_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic [NB_REG-1:0]  index_q;
    logic [NB_DATA-1:0] data_q;
    logic               last;
    logic               hs;

    // Last beat is the all-ones index, so the counter never has to wrap
    assign last = &index_q;
    assign hs   = valid_q & i_dump_ready;

    // The bank is asked for the entry that the next load will capture
    assign o_rd_addr = (state_q == IDLE) ? '0 : index_q + 1'b1;

    // Dump FSM: index and data only move on a handshake, so a stalled beat stays frozen
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_dump_start) begin
                    state_q <= STREAM;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    index_q <= '0;
                    data_q  <= i_rd_data;
                end
                STREAM: if (hs) begin
                    if (last) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        index_q <= index_q + 1'b1;
                        data_q  <= i_rd_data;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_dump_valid = valid_q;
    assign o_dump_index = index_q;
    assign o_dump_data  = data_q;
    assign o_dump_busy  = busy_q;
    assign o_dump_done  = done_q;

endmodule

// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read-port register file with write bypass, optional zero r0 and a dump engine
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_REG   = NB_REG_DEF,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_READ*NB_REG-1:0]  i_read_addr,
    output logic [N_READ*NB_DATA-1:0] o_read_data,
    input  logic                      i_write_enable,
    input  logic [NB_REG-1:0]         i_write_reg,
    input  logic [NB_DATA-1:0]        i_write_data,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    output logic                      o_dump_valid,
    output logic [NB_REG-1:0]         o_dump_index,
    output logic [NB_DATA-1:0]        o_dump_data,
    output logic                      o_dump_busy,
    output logic                      o_dump_done
);

    localparam int DEPTH  = 2 ** NB_REG;
    localparam int N_PORT = N_READ + 1;

    logic [NB_DATA-1:0] regs_q [DEPTH];
    logic [NB_REG-1:0]  rd_addr [N_PORT];
    logic [NB_DATA-1:0] rd_data [N_PORT];
    logic [NB_REG-1:0]  dump_addr;
    logic               write_en_d;

    // Writes to r0 are discarded when it is the hardwired zero register
    assign write_en_d = i_write_enable && !(ZERO_REG != 0 && i_write_reg == '0);

    // Storage: reset clears the whole bank and wins over a pending write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (write_en_d) begin
            regs_q[i_write_reg] <= i_write_data;
        end
    end

    // The dump engine gets an extra read port so it never steals an external one
    genvar k;
    generate
        for (k = 0; k < N_PORT; k++) begin : g_rd
            if (k < N_READ) begin : g_ext
                assign rd_addr[k] = i_read_addr[k*NB_REG +: NB_REG];
                assign o_read_data[k*NB_DATA +: NB_DATA] = rd_data[k];
            end else begin : g_dump
                assign rd_addr[k] = dump_addr;
            end
            assign rd_data[k] = (ZERO_REG != 0 && rd_addr[k] == '0) ? '0 :
                                (BYPASS != 0 && i_write_enable && rd_addr[k] == i_write_reg) ? i_write_data :
                                regs_q[rd_addr[k]];
        end
    endgenerate

    register_bank_mp_dump_seq #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG)
    ) u_dump (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .i_rd_data    (rd_data[N_READ]),
        .o_rd_addr    (dump_addr),
        .o_dump_valid (o_dump_valid),
        .o_dump_index (o_dump_index),
        .o_dump_data  (o_dump_data),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: read/write vector table on two builds plus scoreboarded dump sequences
module tb_register_bank_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wreg = '0;
    logic [31:0] wdata = '0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [9:0]  ra_a = '0;
    logic [14:0] ra_b = '0;
    logic [63:0] rd_a;
    logic [95:0] rd_b;
    logic        dv_a, busy_a, done_a, dv_b, busy_b, done_b;
    logic [4:0]  di_a, di_b;
    logic [31:0] dd_a, dd_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1;
        logic [31:0] f0, f1, f2;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    vec_t  vecs [11];
    beat_t sb [$];
    beat_t b;
    int    cyc;

    always #5 clk = ~clk;

    register_bank_mp dut_a (
        .i_clk(clk), .i_reset(rst), .i_read_addr(ra_a), .o_read_data(rd_a),
        .i_write_enable(we), .i_write_reg(wreg), .i_write_data(wdata),
        .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dv_a),
        .o_dump_index(di_a), .o_dump_data(dd_a), .o_dump_busy(busy_a), .o_dump_done(done_a)
    );

    register_bank_mp #(.N_READ(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_read_addr(ra_b), .o_read_data(rd_b),
        .i_write_enable(we), .i_write_reg(wreg), .i_write_data(wdata),
        .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dv_b),
        .o_dump_index(di_b), .o_dump_data(dd_b), .o_dump_busy(busy_b), .o_dump_done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        we = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // we wreg wdata ra0 ra1 ra2 | dut_a e0 e1 | dut_b f0 f1 f2
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 5'd7,  32'hA3A3A3A3, 5'd7,  5'd0,  5'd7,  32'hA3A3A3A3, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  5'd7,  32'hA3A3A3A3, 32'h0,        32'hA3A3A3A3, 32'h0,        32'hA3A3A3A3};
        vecs[3]  = '{1'b1, 5'd0,  32'hA5A5A5A5, 5'd0,  5'd7,  5'd0,  32'h0,        32'hA3A3A3A3, 32'h0,        32'hA3A3A3A3, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,  5'd3,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1'b1, 5'd1,  32'h11,       5'd3,  5'd3,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'hA3A3A3A3};
        vecs[7]  = '{1'b1, 5'd2,  32'h22,       5'd1,  5'd2,  5'd1,  32'h11,       32'h22,       32'h11,       32'h0,        32'h11};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd1,  32'h11,       32'h22,       32'h11,       32'h22,       32'h11};
        vecs[9]  = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd30, 5'd31, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

        do_reset();
        #1;
        chk("reset valid", 32'(dv_a), 32'd0);
        chk("reset busy", 32'(busy_a), 32'd0);
        chk("reset done", 32'(done_a), 32'd0);
        chk("reset index", 32'(di_a), 32'd0);
        chk("reset data", dd_a, 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            wreg = vecs[i].wreg;
            wdata = vecs[i].wdata;
            ra_a = {vecs[i].ra1, vecs[i].ra0};
            ra_b = {vecs[i].ra2, vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("v%0d a.p0", i), rd_a[31:0], vecs[i].e0);
            chk($sformatf("v%0d a.p1", i), rd_a[63:32], vecs[i].e1);
            chk($sformatf("v%0d b.p0", i), rd_b[31:0], vecs[i].f0);
            chk($sformatf("v%0d b.p1", i), rd_b[63:32], vecs[i].f1);
            chk($sformatf("v%0d b.p2", i), rd_b[95:64], vecs[i].f2);
        end

        do_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1;
            wreg = 5'(i);
            wdata = 32'(i * 4);
        end
        @(negedge clk);
        we = 1'b0;
        ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 32; i++) sb.push_back('{5'(i), 32'(i * 4)});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (sb.size() > 0 && cyc < 40) begin
            if (dv_a && ready) begin
                b = sb.pop_front();
                chk($sformatf("beat%0d index", b.idx), 32'(di_a), 32'(b.idx));
                chk($sformatf("beat%0d data", b.idx), dd_a, b.data);
                chk($sformatf("beat%0d b.data", b.idx), dd_b, b.data);
            end
            @(negedge clk);
            cyc++;
        end
        chk("dump beats left", 32'(sb.size()), 32'd0);
        sb.delete();
        chk("done cycle", 32'(cyc), 32'd33);
        chk("done pulse", 32'(done_a), 32'd1);
        chk("done valid", 32'(dv_a), 32'd0);
        chk("done busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("after done", 32'(done_a), 32'd0);
        chk("after busy", 32'(busy_a), 32'd0);
        chk("after valid", 32'(dv_a), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall pre%0d index", i), 32'(di_a), 32'(i));
            chk($sformatf("stall pre%0d data", i), dd_a, 32'(i * 4));
            @(negedge clk);
        end
        chk("stall index", 32'(di_a), 32'd5);
        ready = 1'b0;
        we = 1'b1;
        wreg = 5'd5;
        wdata = 32'hFFFF;
        ra_a = {5'd0, 5'd5};
        #1;
        chk("stall bypass read", rd_a[31:0], 32'hFFFF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            we = 1'b0;
            #1;
            chk($sformatf("hold%0d index", i), 32'(di_a), 32'd5);
            chk($sformatf("hold%0d data", i), dd_a, 32'd20);
            chk($sformatf("hold%0d valid", i), 32'(dv_a), 32'd1);
            chk($sformatf("hold%0d read r5", i), rd_a[31:0], 32'hFFFF);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("resume index", 32'(di_a), 32'd6);
        chk("resume data", dd_a, 32'd24);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset valid", 32'(dv_a), 32'd0);
        chk("midreset busy", 32'(busy_a), 32'd0);
        chk("midreset index", 32'(di_a), 32'd0);
        chk("midreset r5", rd_a[31:0], 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midreset done%0d", i), 32'(done_a), 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
